// File: rtl/bomb_drop.sv
// rtl/bomb_drop.sv - falling enemy bomb sprite with below-row collision sensing and blast
module bomb_drop #(
   parameter int XSIZE         = 5,
   parameter int YSIZE         = 5,
   parameter int STEP          = 1,
   parameter int YMAX          = 479,
   parameter int XMAX          = 639,
   parameter int EXPLODE_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pixpulse,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       empty,
   input  logic       move,
   input  logic       fire,
   input  logic [9:0] fire_x,
   input  logic [9:0] fire_y,
   output logic       fire_ack,
   output logic       draw_bomb,
   output logic [9:0] xloc,
   output logic [9:0] yloc,
   output logic       busy,
   output logic       hit,
   output logic       exploding
);

   localparam int HALF  = (XSIZE - 1) / 2;
   localparam int VHALF = (YSIZE - 1) / 2;
   localparam int CW    = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

   // 11-bit copies so sprite-edge arithmetic never wraps at the screen edges
   localparam logic [10:0] HALF_W  = 11'(HALF);
   localparam logic [10:0] VHALF_W = 11'(VHALF);
   localparam logic [10:0] STEP_W  = 11'(STEP);
   localparam logic [10:0] YMAX_W  = 11'(YMAX);

   localparam logic [9:0] X_LO = 10'(HALF);
   localparam logic [9:0] X_HI = 10'(XMAX - HALF);
   localparam logic [9:0] Y_LO = 10'(VHALF);
   localparam logic [9:0] Y_HI = 10'(YMAX - VHALF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FALL  = 2'd1,
      BLAST = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      xloc_q, xloc_d;
   logic [9:0]      yloc_q, yloc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XSIZE-1:0] below_q, below_d;
   logic            clr_q, clr_d;
   logic            ack_q, ack_d;
   logic            hit_q, hit_d;

   logic [10:0] hc_w, vc_w, xl_w, yl_w;

   assign hc_w = {1'b0, hcount};
   assign vc_w = {1'b0, vcount};
   assign xl_w = {1'b0, xloc_q};
   assign yl_w = {1'b0, yloc_q};

   function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lo,
                                        input logic [9:0] hi);
      if (v < lo)
         return lo;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

   // sprite coverage: bomb or blast drawn at the current centre whenever active
   always_comb begin
      draw_bomb = 1'b0;
      if (state_q != IDLE &&
          hc_w + HALF_W >= xl_w && hc_w <= xl_w + HALF_W &&
          vc_w + VHALF_W >= yl_w && vc_w <= yl_w + VHALF_W)
         draw_bomb = 1'b1;
   end

   // next-state: launch, fall, blast countdown and below-row occupancy capture
   always_comb begin
      state_d = state_q;
      xloc_d  = xloc_q;
      yloc_d  = yloc_q;
      cnt_d   = cnt_q;
      below_d = below_q;
      clr_d   = clr_q;
      ack_d   = 1'b0;
      hit_d   = 1'b0;

      if (pixpulse) begin
         // the row beneath is re-sampled every frame; a move restarts it
         clr_d = move;
         if (clr_q) begin
            below_d = '0;
         end else if (state_q == FALL && !empty && vc_w == yl_w + VHALF_W + 11'd1) begin
            for (int i = 0; i < XSIZE; i++) begin
               if (hc_w == xl_w - HALF_W + 11'(i))
                  below_d[i] = 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               if (fire) begin
                  xloc_d  = clamp(fire_x, X_LO, X_HI);
                  yloc_d  = clamp(fire_y, Y_LO, Y_HI);
                  below_d = '0;
                  ack_d   = 1'b1;
                  state_d = FALL;
               end
            end
            FALL: begin
               if (move) begin
                  if (|below_q) begin
                     hit_d   = 1'b1;
                     cnt_d   = CW'(EXPLODE_TICKS - 1);
                     state_d = BLAST;
                  end else if (yl_w + VHALF_W + STEP_W > YMAX_W) begin
                     state_d = IDLE;
                  end else begin
                     yloc_d = yloc_q + 10'(STEP);
                  end
               end
            end
            BLAST: begin
               if (move) begin
                  if (cnt_q == '0)
                     state_d = IDLE;
                  else
                     cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         xloc_q  <= '0;
         yloc_q  <= '0;
         cnt_q   <= '0;
         below_q <= '0;
         clr_q   <= 1'b0;
         ack_q   <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         xloc_q  <= xloc_d;
         yloc_q  <= yloc_d;
         cnt_q   <= cnt_d;
         below_q <= below_d;
         clr_q   <= clr_d;
         ack_q   <= ack_d;
         hit_q   <= hit_d;
      end
   end

   assign fire_ack  = ack_q;
   assign hit       = hit_q;
   assign xloc      = xloc_q;
   assign yloc      = yloc_q;
   assign busy      = (state_q != IDLE);
   assign exploding = (state_q == BLAST);

endmodule

// File: tb/tb_bomb_drop.sv
// tb/tb_bomb_drop.sv - directed self-checking bench for bomb_drop
module tb_bomb_drop;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pixpulse = 1'b0;
   logic [9:0] hcount = '0;
   logic [9:0] vcount = '0;
   logic       empty = 1'b1;
   logic       move = 1'b0;
   logic       fire = 1'b0;
   logic [9:0] fire_x = '0;
   logic [9:0] fire_y = '0;
   logic       fire_ack, draw_bomb, busy, hit, exploding;
   logic [9:0] xloc, yloc;

   int vectors = 0;
   int miscompares = 0;
   int ack_cnt = 0;
   int hit_cnt = 0;
   int both_cnt = 0;

   bomb_drop dut (
      .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
      .empty(empty), .move(move), .fire(fire), .fire_x(fire_x), .fire_y(fire_y),
      .fire_ack(fire_ack), .draw_bomb(draw_bomb), .xloc(xloc), .yloc(yloc),
      .busy(busy), .hit(hit), .exploding(exploding)
   );

   always #5 clk = ~clk;

   // count clocks in which each pulse output is high
   always @(negedge clk) begin
      if (fire_ack) ack_cnt++;
      if (hit) hit_cnt++;
      if (fire_ack && hit) both_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one pixel-rate slot (4 clks) with the given scan position and controls
   task automatic px(input int h, input int v, input logic e, input logic mv, input logic fr);
      @(negedge clk);
      hcount = 10'(h); vcount = 10'(v); empty = e; move = mv; fire = fr; pixpulse = 1'b1;
      @(negedge clk);
      pixpulse = 1'b0; move = 1'b0; fire = 1'b0; empty = 1'b1; hcount = '0; vcount = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic mv_n(input int n);
      for (int i = 0; i < n; i++) px(0, 0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic launch(input int x, input int y);
      fire_x = 10'(x); fire_y = 10'(y);
      px(0, 0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      #1;
   endtask

   task automatic draw_at(input string tag, input int h, input int v, input int exp);
      @(negedge clk);
      hcount = 10'(h); vcount = 10'(v);
      #1 chk(tag, int'(draw_bomb), exp);
      hcount = '0; vcount = '0;
   endtask

   int a0, h0;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_xloc", int'(xloc), 0);
      chk("rst_yloc", int'(yloc), 0);
      chk("rst_draw", int'(draw_bomb), 0);
      chk("rst_expl", int'(exploding), 0);
      chk("rst_ack", int'(fire_ack), 0);

      // reset mid-flight
      launch(100, 50);
      mv_n(3);
      chk("mid_yloc_pre", int'(yloc), 53);
      do_reset();
      chk("mid_busy", int'(busy), 0);
      chk("mid_xloc", int'(xloc), 0);
      chk("mid_yloc", int'(yloc), 0);
      chk("mid_draw", int'(draw_bomb), 0);
      chk("mid_hit", hit_cnt, 0);

      // launch
      a0 = ack_cnt;
      launch(100, 50);
      chk("ack_width", ack_cnt - a0, 1);
      chk("launch_busy", int'(busy), 1);
      chk("launch_xloc", int'(xloc), 100);
      chk("launch_yloc", int'(yloc), 50);
      draw_at("draw_98_48", 98, 48, 1);
      draw_at("draw_102_52", 102, 52, 1);
      draw_at("draw_97_50", 97, 50, 0);
      draw_at("draw_103_50", 103, 50, 0);
      draw_at("draw_100_47", 100, 47, 0);
      draw_at("draw_100_53", 100, 53, 0);
      a0 = ack_cnt;
      launch(300, 300);
      chk("refire_ack", ack_cnt - a0, 0);
      chk("refire_xloc", int'(xloc), 100);
      chk("refire_yloc", int'(yloc), 50);

      // free fall, 10 frames
      h0 = hit_cnt;
      mv_n(10);
      chk("fall_yloc", int'(yloc), 60);
      chk("fall_hit", hit_cnt - h0, 0);
      chk("fall_expl", int'(exploding), 0);

      // collision below the bomb
      do_reset();
      launch(100, 50);
      h0 = hit_cnt;
      px(101, 53, 1'b0, 1'b0, 1'b0);
      mv_n(1);
      chk("coll_hit", hit_cnt - h0, 1);
      chk("coll_expl", int'(exploding), 1);
      chk("coll_yloc", int'(yloc), 50);
      draw_at("coll_draw", 100, 50, 1);
      mv_n(7);
      chk("blast7_busy", int'(busy), 1);
      mv_n(1);
      chk("blast8_busy", int'(busy), 0);
      chk("blast_hit_once", hit_cnt - h0, 1);
      chk("no_ack_hit_overlap", both_cnt, 0);

      // occupancy outside the window is ignored
      do_reset();
      launch(100, 50);
      h0 = hit_cnt;
      px(104, 53, 1'b0, 1'b0, 1'b0);
      mv_n(1);
      chk("offx_hit", hit_cnt - h0, 0);
      chk("offx_yloc", int'(yloc), 51);
      do_reset();
      launch(100, 50);
      px(101, 54, 1'b0, 1'b0, 1'b0);
      mv_n(1);
      chk("offy_hit", hit_cnt - h0, 0);
      chk("offy_yloc", int'(yloc), 51);

      // bottom edge exit
      do_reset();
      launch(200, 475);
      h0 = hit_cnt;
      mv_n(1);
      chk("bot_y1", int'(yloc), 476);
      mv_n(1);
      chk("bot_y2", int'(yloc), 477);
      mv_n(1);
      chk("bot_busy", int'(busy), 0);
      chk("bot_yloc", int'(yloc), 477);
      chk("bot_hit", hit_cnt - h0, 0);

      // clamp low with simultaneous move: fire wins
      do_reset();
      fire_x = 10'd1; fire_y = 10'd0;
      px(0, 0, 1'b1, 1'b1, 1'b1);
      chk("clamp_xlo", int'(xloc), 2);
      chk("clamp_ylo", int'(yloc), 2);
      chk("clamp_busy", int'(busy), 1);
      px(0, 0, 1'b1, 1'b0, 1'b0);
      chk("prio_nomove", int'(yloc), 2);

      // clamp high
      do_reset();
      launch(700, 479);
      chk("clamp_xhi", int'(xloc), 637);
      chk("clamp_yhi", int'(yloc), 477);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
